// File: rtl/nn_stream_controller_pkg.sv
// nn_stream_controller_pkg
// Shared fixed-point types and helpers for the neural_network host-side
// stream controller.
//   fixed_point        : {integral, fraction} element, copied bit-exact
//   nn_stream_state_t  : controller FSM states
//   cnt_width()        : counter width for a given element count
package nn_stream_controller_pkg;

  localparam int INTEGRAL_WIDTH = 8;
  localparam int FRACTION_WIDTH = 8;
  localparam int FIXED_WIDTH    = INTEGRAL_WIDTH + FRACTION_WIDTH;

  typedef struct packed {
    logic [INTEGRAL_WIDTH-1:0] integral;
    logic [FRACTION_WIDTH-1:0] fraction;
  } fixed_point;

  typedef enum logic [1:0] {
    LOAD,
    START,
    WAIT,
    UNLOAD
  } nn_stream_state_t;

  // A count of 1 still gets a one-bit counter so zero-width vectors never appear.
  function automatic int cnt_width(input int n);
    return $clog2((n < 2) ? 2 : n);
  endfunction

endpackage

// File: rtl/nn_argmax_tracker.sv
// nn_argmax_tracker
// Running signed maximum over the elements streamed out of the controller.
// Each element is compared as a signed two's-complement {integral,fraction};
// ties keep the lowest index.
// Ports:
//   clock, reset      : clock, asynchronous active-low reset
//   xfer              : an element is transferred this cycle
//   last              : the transferred element is the final one of the frame
//   index, data       : position and value of the element on the stream
//   class_index       : index of the frame maximum, held until the next frame
//   class_valid       : one-cycle pulse the cycle after the final transfer
module nn_argmax_tracker
  import nn_stream_controller_pkg::*;
#(
  parameter int NUM_OUTPUTS = 10
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              xfer,
  input  logic                              last,
  input  logic [cnt_width(NUM_OUTPUTS)-1:0] index,
  input  fixed_point                        data,
  output logic [cnt_width(NUM_OUTPUTS)-1:0] class_index,
  output logic                              class_valid
);

  localparam int IW = cnt_width(NUM_OUTPUTS);

  logic signed [FIXED_WIDTH-1:0] value;
  logic signed [FIXED_WIDTH-1:0] best_value;
  logic [IW-1:0]                 best_index;
  logic                          take;

  assign value = $signed({data.integral, data.fraction});

  // Element 0 always seeds the maximum; a strict compare keeps the lowest index on ties.
  assign take = (index == '0) || (value > best_value);

  // The final transfer resolves the winner directly so class_index is valid
  // in the same cycle as the class_valid pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      best_value  <= '0;
      best_index  <= '0;
      class_index <= '0;
      class_valid <= 1'b0;
    end else begin
      class_valid <= xfer && last;
      if (xfer) begin
        if (take) begin
          best_value <= value;
          best_index <= index;
        end
        if (last) begin
          class_index <= take ? index : best_index;
        end
      end
    end
  end

endmodule

// File: rtl/nn_stream_controller.sv
// nn_stream_controller
// Host-side driver for neural_network: packs NUM_INPUTS streamed samples into
// the parallel inputs vector, pulses inputs_ready, waits for outputs_ready,
// captures the result vector and streams it back out with a last marker.
// Ports:
//   clock, reset                : clock, asynchronous active-low reset
//   in_data/in_valid/in_ready   : input sample stream from the host
//   inputs, inputs_ready        : parallel vector and start pulse to the network
//   outputs, outputs_ready      : result vector and strobe from the network
//   out_data/out_valid/out_ready/out_last : result stream back to the host
//   busy                        : high whenever a frame is in flight
// Optional build macro NN_STREAM_ARGMAX_EN adds class_index/class_valid,
// the signed argmax of each result frame.
module nn_stream_controller
  import nn_stream_controller_pkg::*;
#(
  parameter int NUM_INPUTS  = 10,
  parameter int NUM_OUTPUTS = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  fixed_point in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output fixed_point inputs [NUM_INPUTS],
  output logic       inputs_ready,
  input  fixed_point outputs [NUM_OUTPUTS],
  input  logic       outputs_ready,
  output fixed_point out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       busy
`ifdef NN_STREAM_ARGMAX_EN
  ,
  output logic [cnt_width(NUM_OUTPUTS)-1:0] class_index,
  output logic                              class_valid
`endif
);

  localparam int LW = cnt_width(NUM_INPUTS);
  localparam int UW = cnt_width(NUM_OUTPUTS);
  localparam logic [LW-1:0] LOAD_LAST   = LW'(NUM_INPUTS - 1);
  localparam logic [UW-1:0] UNLOAD_LAST = UW'(NUM_OUTPUTS - 1);

  nn_stream_state_t state, next_state;
  logic [LW-1:0]    load_cnt;
  logic [UW-1:0]    unload_cnt;
  logic             started;
  fixed_point       buffer [NUM_OUTPUTS];
  logic             in_xfer;
  logic             out_xfer;
  logic             capture;

  // started keeps in_ready low until the first edge after reset release.
  assign in_xfer  = in_valid && started && (state == LOAD);
  assign out_xfer = out_ready && (state == UNLOAD);
  assign capture  = outputs_ready && (state == WAIT);

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= LOAD;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and stream handshake outputs; out_data is forced to zero
  // outside UNLOAD so a stale buffer entry never shows on the host stream.
  always_comb begin
    next_state   = state;
    in_ready     = 1'b0;
    inputs_ready = 1'b0;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    out_data     = '0;
    busy         = 1'b1;
    case (state)
      LOAD: begin
        in_ready = started;
        busy     = 1'b0;
        if (in_xfer && (load_cnt == LOAD_LAST)) begin
          next_state = START;
        end
      end
      START: begin
        inputs_ready = 1'b1;
        next_state   = WAIT;
      end
      WAIT: begin
        if (capture) begin
          next_state = UNLOAD;
        end
      end
      UNLOAD: begin
        out_valid = 1'b1;
        out_data  = buffer[unload_cnt];
        out_last  = (unload_cnt == UNLOAD_LAST);
        if (out_xfer && (unload_cnt == UNLOAD_LAST)) begin
          next_state = LOAD;
        end
      end
      default: next_state = LOAD;
    endcase
  end

  // Datapath: input packing, result capture and the two element counters.
  // The inputs vector only changes on a LOAD write, so it stays stable for
  // the network from START until the next frame begins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      started    <= 1'b0;
      load_cnt   <= '0;
      unload_cnt <= '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        inputs[i] <= '0;
      end
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
        buffer[i] <= '0;
      end
    end else begin
      started <= 1'b1;
      if (in_xfer) begin
        inputs[load_cnt] <= in_data;
        load_cnt         <= (load_cnt == LOAD_LAST) ? '0 : load_cnt + 1'b1;
      end
      if (capture) begin
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
          buffer[i] <= outputs[i];
        end
      end
      if (out_xfer) begin
        unload_cnt <= (unload_cnt == UNLOAD_LAST) ? '0 : unload_cnt + 1'b1;
      end
    end
  end

`ifdef NN_STREAM_ARGMAX_EN
  nn_argmax_tracker #(
    .NUM_OUTPUTS (NUM_OUTPUTS)
  ) u_argmax (
    .clock       (clock),
    .reset       (reset),
    .xfer        (out_xfer),
    .last        (out_last),
    .index       (unload_cnt),
    .data        (out_data),
    .class_index (class_index),
    .class_valid (class_valid)
  );
`endif

endmodule

// File: doc/nn_stream_controller.md
Name: nn_stream_controller

Overview:
- Drives the `neural_network` from the host side and returns its results.
- Accepts a serial stream of fixed_point samples and packs NUM_INPUTS of them into the parallel `inputs` vector.
- Pulses `inputs_ready`, waits for `outputs_ready`, captures `outputs`, then serialises them on an output stream with a last marker.
- Sits between the host/DMA stream fabric and `neural_network` in the top level.

Parameters:
- NUM_INPUTS, 10, number of fixed_point elements in the network input vector (matches layer 0 SIZE).
- NUM_OUTPUTS, 10, number of fixed_point elements in the network output vector (matches last layer SIZE).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_data  input  fixed_point  sample from host stream.
- in_valid  input  1  in_data valid.
- in_ready  output  1  controller can accept a sample.
- inputs  output  fixed_point[NUM_INPUTS]  parallel vector to neural_network.
- inputs_ready  output  1  one-cycle start pulse to neural_network.
- outputs  input  fixed_point[NUM_OUTPUTS]  result vector from neural_network.
- outputs_ready  input  1  result valid strobe from neural_network.
- out_data  output  fixed_point  result element to host.
- out_valid  output  1  out_data valid.
- out_ready  input  1  host accepts out_data.
- out_last  output  1  high with the final element (index NUM_OUTPUTS-1).
- busy  output  1  high in any state other than LOAD.

Behaviour:
- Reset (reset low, async assert, sync deassert internally irrelevant):
  - state=LOAD; load and unload counters 0.
  - inputs[] all 0; output buffer all 0.
  - in_ready=0 while reset is low, then 1 in the first cycle after release.
  - inputs_ready=0, out_valid=0, out_last=0, out_data=0, busy=0.
- Counter widths are $clog2 of the larger of the count and 2. No arithmetic is performed on data; elements are copied bit-exact.
- FSM states LOAD, START, WAIT, UNLOAD:
  - LOAD:
    - in_ready=1.
    - On in_valid&&in_ready, write inputs[load_cnt]=in_data and increment load_cnt.
    - On the transfer with load_cnt==NUM_INPUTS-1, clear load_cnt and go to START.
  - START:
    - in_ready=0, inputs_ready=1 for exactly this one cycle; go to WAIT.
    - The inputs vector is held stable from START until the next LOAD write.
  - WAIT:
    - in_ready=0.
    - On outputs_ready=1, register all outputs[] into the buffer and go to UNLOAD.
    - outputs_ready is sampled only in WAIT; it is ignored in LOAD, START and UNLOAD.
  - UNLOAD:
    - out_valid=1, out_data=buffer[unload_cnt], out_last=(unload_cnt==NUM_OUTPUTS-1).
    - On out_valid&&out_ready, increment unload_cnt.
    - On the last transfer, clear unload_cnt, drop out_valid/out_last in the next cycle and return to LOAD.
    - out_data, out_valid and out_last are stable while out_ready=0.
- Latency:
  - Last input accepted at edge N → inputs_ready high in cycle N+1.
  - outputs_ready sampled at edge M → out_valid high in cycle M+1.
  - Last output accepted at edge K → in_ready high in cycle K+1.
- No overlap: a new frame is not accepted until the previous frame is fully unloaded.
- Reset asserted mid-frame aborts immediately: partial input frame discarded, pending output discarded, all outputs return to reset values.
- in_valid while in_ready=0 is held off; no data loss, no error flag.

Optional Feature:
- Macro: NN_STREAM_ARGMAX_EN.
- Defined:
  - Adds output ports class_index [$clog2(NUM_OUTPUTS)] and class_valid [1].
  - During UNLOAD, a running argmax over transferred elements, each compared as a signed two's-complement {integral,fraction}.
  - Ties resolve to the lowest index.
  - class_valid pulses one cycle, coincident with the cycle after the out_last transfer; class_index holds until the next pulse.
  - Both are reset to 0.
- Undefined: ports absent, no comparator logic; the stream behaviour is identical in both builds.

Decomposition:
- Shared package (existing include.svh contents):
  - fixed_point struct (integral, fraction).
  - INTEGRAL_WIDTH, FRACTION_WIDTH.
  - new nn_stream_state_t enum {LOAD, START, WAIT, UNLOAD}.
- Natural sub-module: nn_argmax_tracker, the running signed max plus index, instantiated only under NN_STREAM_ARGMAX_EN.

Test Plan:
- Basic frame:
  - Stimulus: stream 10 samples 0.5 (integral 0, fraction MSB set), out_ready=1, neural_network model returns outputs[i]=i after 5 cycles.
  - Response: single inputs_ready pulse one cycle after the 10th sample; 10 outputs 0..9 in order; out_last only on value 9.
- Backpressure:
  - Stimulus: out_ready toggling 1,0,0,1.
  - Response: out_data/out_valid held during stalls; exactly 10 transfers; in_ready stays 0 until the last transfer completes.
- Input gaps:
  - Stimulus: in_valid deasserted randomly mid-frame.
  - Response: inputs_ready only after the 10th accepted sample; inputs[] contents match the stream order.
- Spurious strobe:
  - Stimulus: outputs_ready=1 while in LOAD after 3 samples.
  - Response: ignored; busy=0; frame continues normally.
- Reset mid-WAIT:
  - Stimulus: reset low for 2 cycles.
  - Response: inputs_ready=0, out_valid=0, inputs[] all 0, in_ready=1 the cycle after release; the next full frame completes correctly.
- ARGMAX_EN:
  - Stimulus: outputs {1,7,-3,7,…,0}.
  - Response: class_index=1 (tie to lowest), one class_valid pulse after out_last.
